// File: rtl/store_buffer_pkg.sv
// Shared widths and the entry record for the store buffer.
// Entry fields are sized here, so instances must not use ADDR_W/DATA_W wider than these defaults.
package store_buffer_pkg;

    localparam int SB_ADDR_W = 32;
    localparam int SB_DATA_W = 32;

    typedef struct packed {
        logic                 valid;
        logic [SB_ADDR_W-1:0] addr;
        logic [SB_DATA_W-1:0] data;
    } sb_entry_t;

endpackage

// File: rtl/store_buffer_if.sv
// Pipeline-side store/load signals and memory-side write port of the store buffer.
// The slave modport is the buffer itself; the master modport is its environment.
interface store_buffer_if
    import store_buffer_pkg::*;
#(
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) ();

    logic              StoreValid;
    logic [ADDR_W-1:0] StoreAddr;
    logic [DATA_W-1:0] StoreData;
    logic              StoreReady;
    logic              LoadValid;
    logic [ADDR_W-1:0] LoadAddr;
    logic              LoadHit;
    logic [DATA_W-1:0] LoadData;
    logic              MemBusy;
    logic              MemWriteEnable;
    logic [ADDR_W-1:0] MemAddress;
    logic [DATA_W-1:0] MemWriteData;

    modport master (
        output StoreValid, StoreAddr, StoreData, LoadValid, LoadAddr, MemBusy,
        input  StoreReady, LoadHit, LoadData, MemWriteEnable, MemAddress, MemWriteData
    );

    modport slave (
        input  StoreValid, StoreAddr, StoreData, LoadValid, LoadAddr, MemBusy,
        output StoreReady, LoadHit, LoadData, MemWriteEnable, MemAddress, MemWriteData
    );

endinterface

// File: rtl/store_buffer_match.sv
// Youngest-match lookup: scans live entries oldest to youngest so the last hit wins.
module store_buffer_match
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  sb_entry_t                entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0] head,
    input  logic [$clog2(DEPTH):0]   count,
    input  logic [ADDR_W-1:0]        addr,
    output logic                     hit,
    output logic [DATA_W-1:0]        data
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] idx;

    // Age order is head, head+1, ...; only the first `count` slots are live.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && entries[idx].valid &&
                (entries[idx].addr == SB_ADDR_W'(addr))) begin
                hit  = 1'b1;
                data = DATA_W'(entries[idx].data);
            end
        end
    end

endmodule

// File: rtl/store_buffer.sv
// In-order store buffer in front of the data memory, with youngest-match load forwarding.
// Optional feature: define STORE_BUFFER_COALESCE_EN to merge a store into the youngest entry of equal address.
module store_buffer
    import store_buffer_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = SB_ADDR_W,
    parameter int DATA_W = SB_DATA_W
) (
    input  logic                   Clock,
    input  logic                   Reset_n,
    store_buffer_if.slave          bus,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t         entries [DEPTH];
    logic [PTR_W-1:0]  headPtr;
    logic [PTR_W-1:0]  tailPtr;
    logic [PTR_W-1:0]  youngPtr;
    logic [CNT_W-1:0]  count;
    logic              notEmpty;
    logic              notFull;
    logic              drain;
    logic              coalesceMatch;
    logic              coalesce;
    logic              enqueue;
    logic              matchHit;
    logic [DATA_W-1:0] matchData;

    assign notEmpty = (count != '0);
    assign notFull  = (count < CNT_W'(DEPTH));
    assign youngPtr = tailPtr - PTR_W'(1);
    assign drain    = notEmpty & ~bus.MemBusy;

`ifdef STORE_BUFFER_COALESCE_EN
    // A head entry leaving on this edge cannot absorb the store; it is enqueued fresh instead.
    assign coalesceMatch = notEmpty && entries[youngPtr].valid &&
                           (entries[youngPtr].addr == SB_ADDR_W'(bus.StoreAddr)) &&
                           !((youngPtr == headPtr) && drain);
`else
    assign coalesceMatch = 1'b0;
`endif

    assign coalesce = bus.StoreValid & coalesceMatch;
    assign enqueue  = bus.StoreValid & notFull & ~coalesceMatch;

    assign bus.StoreReady     = notFull | coalesceMatch;
    assign bus.MemWriteEnable = drain;
    assign bus.MemAddress     = notEmpty ? ADDR_W'(entries[headPtr].addr) : '0;
    assign bus.MemWriteData   = notEmpty ? DATA_W'(entries[headPtr].data) : '0;
    assign Count              = count;

    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            headPtr <= '0;
            tailPtr <= '0;
            count   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entries[i].valid <= 1'b0;
            end
        end else begin
            // Enqueue and drain never hit the same slot: no enqueue when full, no drain when empty.
            if (drain) begin
                entries[headPtr].valid <= 1'b0;
                headPtr                <= headPtr + PTR_W'(1);
            end
            if (enqueue) begin
                entries[tailPtr] <= '{valid: 1'b1,
                                      addr:  SB_ADDR_W'(bus.StoreAddr),
                                      data:  SB_DATA_W'(bus.StoreData)};
                tailPtr          <= tailPtr + PTR_W'(1);
            end
            if (coalesce) begin
                entries[youngPtr].data <= SB_DATA_W'(bus.StoreData);
            end
            count <= count + CNT_W'(enqueue) - CNT_W'(drain);
        end
    end

    store_buffer_match #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) uMatch (
        .entries(entries),
        .head   (headPtr),
        .count  (count),
        .addr   (bus.LoadAddr),
        .hit    (matchHit),
        .data   (matchData)
    );

    assign bus.LoadHit  = bus.LoadValid & matchHit;
    assign bus.LoadData = bus.LoadValid ? matchData : '0;

endmodule

// File: tb/tb_store_buffer.sv
// Directed and randomized bench for store_buffer against a queue-based reference model.
// Follows STORE_BUFFER_COALESCE_EN the same way the design does.
module tb_store_buffer;

    localparam int DEPTH = 4;
`ifdef STORE_BUFFER_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } store_t;

    logic        clock;
    logic        resetN;
    logic [2:0]  count;
    store_t      mq[$];
    int          nCompared;
    int          nMismatched;

    logic        curSv, curLv, curMb, curRn;
    logic [31:0] curSa, curSd, curLa;

    store_buffer_if #(.ADDR_W(32), .DATA_W(32)) sbIf ();

    store_buffer #(
        .DEPTH (DEPTH),
        .ADDR_W(32),
        .DATA_W(32)
    ) dut (
        .Clock  (clock),
        .Reset_n(resetN),
        .bus    (sbIf),
        .Count  (count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic compareValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nCompared++;
        assert (obs === exp)
        else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit modelWen();
        return (mq.size() > 0) && !curMb;
    endfunction

    function automatic bit modelCoalesce();
        int sz = mq.size();
        return COAL && (sz > 0) && (mq[sz-1].addr == curSa) && !((sz == 1) && modelWen());
    endfunction

    // Compares every combinational output with what the queue model predicts for this cycle.
    task automatic checkOutput();
        int          sz = mq.size();
        logic        expHit = 1'b0;
        logic [31:0] expLd  = '0;
        if (curLv) begin
            for (int i = sz - 1; i >= 0; i--) begin
                if (!expHit && mq[i].addr == curLa) begin
                    expHit = 1'b1;
                    expLd  = mq[i].data;
                end
            end
        end
        compareValue("count", count, sz);
        compareValue("storeReady", sbIf.StoreReady, (sz < DEPTH) || modelCoalesce());
        compareValue("memWriteEnable", sbIf.MemWriteEnable, modelWen());
        compareValue("memAddress", sbIf.MemAddress, (sz > 0) ? mq[0].addr : 32'h0);
        compareValue("memWriteData", sbIf.MemWriteData, (sz > 0) ? mq[0].data : 32'h0);
        compareValue("loadHit", sbIf.LoadHit, expHit);
        compareValue("loadData", sbIf.LoadData, expLd);
    endtask

    task automatic applyStimulus(input logic sv, input logic [31:0] sa, input logic [31:0] sd,
                                 input logic lv, input logic [31:0] la, input logic mb,
                                 input logic rn);
        curSv = sv; curSa = sa; curSd = sd; curLv = lv; curLa = la; curMb = mb; curRn = rn;
        sbIf.StoreValid = sv;
        sbIf.StoreAddr  = sa;
        sbIf.StoreData  = sd;
        sbIf.LoadValid  = lv;
        sbIf.LoadAddr   = la;
        sbIf.MemBusy    = mb;
        resetN          = rn;
        #1;
        checkOutput();
    endtask

    // Advances one clock edge and applies that edge's effect to the model.
    task automatic stepClock();
        int sz;
        bit wen;
        @(posedge clock);
        sz  = mq.size();
        wen = modelWen();
        if (!curRn) begin
            mq.delete();
        end else begin
            if (curSv && modelCoalesce()) begin
                mq[sz-1].data = curSd;
            end else if (curSv && sz < DEPTH) begin
                mq.push_back('{addr: curSa, data: curSd});
            end
            if (wen) void'(mq.pop_front());
        end
        @(negedge clock);
    endtask

    task automatic idleCycle(input logic mb);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, mb, 1'b1);
        stepClock();
    endtask

    task automatic drainAll();
        for (int k = 0; k < 2 * DEPTH && mq.size() > 0; k++) idleCycle(1'b0);
        compareValue("drainEmpty", count, 0);
    endtask

    initial begin
        nCompared   = 0;
        nMismatched = 0;
        curSv = 0; curSa = 0; curSd = 0; curLv = 0; curLa = 0; curMb = 0; curRn = 0;
        sbIf.StoreValid = 0; sbIf.StoreAddr = 0; sbIf.StoreData = 0;
        sbIf.LoadValid  = 0; sbIf.LoadAddr  = 0; sbIf.MemBusy   = 0;
        resetN = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);

        $display("[TB] reset state");
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h0, 1'b0, 1'b1);
        compareValue("rstReady", sbIf.StoreReady, 1);
        compareValue("rstWen", sbIf.MemWriteEnable, 0);
        compareValue("rstCount", count, 0);
        compareValue("rstAddr", sbIf.MemAddress, 0);
        compareValue("rstLoadHit", sbIf.LoadHit, 0);
        stepClock();

        $display("[TB] single store latency");
        applyStimulus(1'b1, 32'h10, 32'h11, 1'b0, 32'h0, 1'b0, 1'b1);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h10, 1'b0, 1'b1);
        compareValue("lat1Wen", sbIf.MemWriteEnable, 1);
        compareValue("lat1Addr", sbIf.MemAddress, 32'h10);
        compareValue("lat1Data", sbIf.MemWriteData, 32'h11);
        compareValue("lat1Fwd", sbIf.LoadData, 32'h11);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        compareValue("lat1CountBack", count, 0);
        stepClock();

        $display("[TB] fill while busy, drain in order");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h40 + 32'(i) * 4, 32'h100 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b1);
            stepClock();
        end
        applyStimulus(1'b1, 32'h80, 32'h999, 1'b0, 32'h0, 1'b1, 1'b1);
        compareValue("fullCount", count, 4);
        compareValue("fullReady", sbIf.StoreReady, 0);
        stepClock();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
            compareValue("drainWen", sbIf.MemWriteEnable, 1);
            compareValue("drainAddr", sbIf.MemAddress, 32'h40 + 32'(i) * 4);
            compareValue("drainData", sbIf.MemWriteData, 32'h100 + 32'(i));
            stepClock();
        end
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        compareValue("drainDone", count, 0);
        stepClock();

        $display("[TB] youngest-match forwarding");
        applyStimulus(1'b1, 32'h20, 32'hA, 1'b0, 32'h0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b1, 32'h20, 32'hB, 1'b0, 32'h0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h20, 1'b1, 1'b1);
        compareValue("fwdHit", sbIf.LoadHit, 1);
        compareValue("fwdData", sbIf.LoadData, 32'hB);
        compareValue("fwdCount", count, COAL ? 1 : 2);
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h24, 1'b1, 1'b1);
        compareValue("fwdMissHit", sbIf.LoadHit, 0);
        compareValue("fwdMissData", sbIf.LoadData, 0);
        stepClock();
        drainAll();

        $display("[TB] full with simultaneous drain and store");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 32'h200 + 32'(i) * 4, 32'h50 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b1);
            stepClock();
        end
        applyStimulus(1'b1, 32'h500, 32'h5, 1'b0, 32'h0, 1'b0, 1'b1);
        compareValue("fullDrainReady", sbIf.StoreReady, 0);
        compareValue("fullDrainWen", sbIf.MemWriteEnable, 1);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b1, 32'h500, 1'b1, 1'b1);
        compareValue("afterCount", count, 3);
        compareValue("afterReady", sbIf.StoreReady, 1);
        compareValue("afterRejected", sbIf.LoadHit, 0);
        stepClock();
        drainAll();

        $display("[TB] reset mid-drain");
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 32'h300 + 32'(i) * 4, 32'h70 + 32'(i), 1'b0, 32'h0, 1'b1, 1'b1);
            stepClock();
        end
        applyStimulus(1'b1, 32'h600, 32'h6, 1'b0, 32'h0, 1'b0, 1'b0);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        compareValue("midRstCount", count, 0);
        compareValue("midRstWen", sbIf.MemWriteEnable, 0);
        compareValue("midRstAddr", sbIf.MemAddress, 0);
        stepClock();
        repeat (3) idleCycle(1'b0);

`ifdef STORE_BUFFER_COALESCE_EN
        $display("[TB] coalescing");
        applyStimulus(1'b1, 32'h30, 32'h1, 1'b0, 32'h0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b1, 32'h30, 32'h2, 1'b0, 32'h0, 1'b1, 1'b1);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        compareValue("coalCount", count, 1);
        compareValue("coalWen", sbIf.MemWriteEnable, 1);
        compareValue("coalData", sbIf.MemWriteData, 32'h2);
        stepClock();
        applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
        compareValue("coalOnce", sbIf.MemWriteEnable, 0);
        stepClock();
`endif

        $display("[TB] randomized traffic");
        for (int n = 0; n < 400; n++) begin
            applyStimulus(1'($urandom_range(0, 1)),
                          32'h1000 + 32'($urandom_range(0, 7)) * 4,
                          $urandom(),
                          1'($urandom_range(0, 1)),
                          32'h1000 + 32'($urandom_range(0, 7)) * 4,
                          ($urandom_range(0, 9) < 4),
                          ($urandom_range(0, 63) != 0));
            stepClock();
        end
        drainAll();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/store_buffer.md
STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 Parameters SHALL be: DEPTH, 4, number of entries (power of two, 2..16); ADDR_W, 32, address width; DATA_W, 32, data width.
REQ-002 Clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 Reset_n  in  1  reset; synchronous and active-low.
REQ-004 StoreValid  in  1  pipeline presents a store this cycle.
REQ-005 StoreAddr  in  ADDR_W  store address.
REQ-006 StoreData  in  DATA_W  store data.
REQ-007 StoreReady  out  1  buffer can accept a store (not full).
REQ-008 LoadValid  in  1  pipeline performs a load this cycle.
REQ-009 LoadAddr  in  ADDR_W  load address.
REQ-010 LoadHit  out  1  load address matches a buffered store.
REQ-011 LoadData  out  DATA_W  forwarded data; 0 when LoadHit=0.
REQ-012 MemBusy  in  1  data memory port is taken by a load this cycle.
REQ-013 MemWriteEnable  out  1  write strobe to data memory.
REQ-014 MemAddress  out  ADDR_W  head entry address.
REQ-015 MemWriteData  out  DATA_W  head entry data.
REQ-016 Count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.

Function
REQ-017 The block SHALL be an in-order FIFO of (address, data) store entries sitting upstream of the data memory.
REQ-018 Enqueue SHALL occur at the edge where StoreValid=1 and StoreReady=1; StoreReady SHALL equal (Count<DEPTH), with no same-cycle drain bypass when full.
REQ-019 MemWriteEnable SHALL be combinational: (Count>0) and MemBusy=0; MemAddress/MemWriteData SHALL always show the head entry (0 when empty).
REQ-020 The head SHALL be dequeued at the edge where MemWriteEnable=1; the memory captures the write on that same edge.
REQ-021 Minimum store-to-memory latency SHALL be one cycle: accepted at edge N, MemWriteEnable high during cycle N+1.
REQ-022 Simultaneous enqueue and dequeue SHALL leave Count unchanged; pointers SHALL wrap modulo DEPTH.
REQ-023 Lookup SHALL compare the full LoadAddr against all valid entries; on multiple matches the youngest SHALL win; LoadHit and LoadData SHALL be combinational and gated by LoadValid.
REQ-024 The head entry SHALL remain visible to lookup during the cycle it drains; a store enqueued at edge N SHALL be visible to lookup from cycle N+1.
REQ-025 Duplicate addresses SHALL be enqueued as separate entries (except as in REQ-029).
REQ-026 MemBusy=1 SHALL hold the head indefinitely with no data loss; StoreValid when full SHALL be ignored.

Reset
REQ-027 Reset_n=0 at an edge SHALL clear pointers, Count and all entry valid bits; afterwards StoreReady=1, MemWriteEnable=0, LoadHit=0, LoadData=0, MemAddress=0, MemWriteData=0.
REQ-028 Reset asserted mid-drain SHALL discard all pending stores; reset SHALL take priority over simultaneous enqueue or dequeue.

Configuration
REQ-029 With STORE_BUFFER_COALESCE_EN defined, a store whose address equals the youngest valid entry SHALL overwrite that entry's data in place without changing Count, unless that entry is the head and is dequeued on the same edge, in which case it SHALL be enqueued normally. Coalescing SHALL occur even when full (StoreReady=1 for that case). Without the macro, every accepted store SHALL occupy a new entry.

Structure
REQ-030 A shared package store_buffer_pkg SHALL hold the ADDR_W/DATA_W defaults and the entry typedef (valid, addr, data).
REQ-031 Youngest-match lookup SHALL be a sub-module store_buffer_match (entry array, head pointer, count, address in; hit and data out).

Verification
REQ-032 Reset, then store A=0x10 D=0x11 with MemBusy=0 -> MemWriteEnable=1, MemAddress=0x10, MemWriteData=0x11 the next cycle; Count returns to 0.
REQ-033 MemBusy=1, 4 stores -> Count=4, StoreReady=0; 5th store ignored; MemBusy=0 -> drains in order, 4 cycles.
REQ-034 Stores 0x20/0xA then 0x20/0xB (macro off), load 0x20 -> LoadHit=1, LoadData=0xB; load 0x24 -> LoadHit=0, LoadData=0.
REQ-035 Full buffer plus simultaneous drain and StoreValid -> store rejected; next cycle Count=3, StoreReady=1.
REQ-036 Count=3, Reset_n=0 one cycle -> Count=0, MemWriteEnable=0, no later writes of the discarded entries.
REQ-037 Macro on, MemBusy=1, stores 0x30/0x1 then 0x30/0x2 -> Count=1; drain writes 0x2 once.
